// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
//   NCH_DEFAULT : default number of requester channels
//   CH_W_MAX    : storage width of the channel field in the response tag
//   ch_w()      : channel index width for n channels (never below 1)
//   resp_tag_t  : in-flight tag {pend, ch, rd} carried to the response cycle
package mem_arb_pkg;

  localparam int unsigned NCH_DEFAULT = 3;
  localparam int unsigned CH_W_MAX    = 8;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                pend;
    logic [CH_W_MAX-1:0] ch;
    logic                rd;
  } resp_tag_t;

endpackage

// File: rtl/arb_picker.sv
// Combinational rotating-priority picker.
// Scans the valid vector starting at channel ptr (wrapping past NCH-1) and
// grants the first valid channel found.
//   valid       : per-channel request valid
//   ptr         : channel that has highest priority this cycle
//   grant       : one-hot grant, zero when nothing is valid
//   grant_idx   : index of the granted channel (0 when none)
//   grant_valid : any channel granted
module arb_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned NCH  = NCH_DEFAULT,
  parameter int unsigned CH_W = ch_w(NCH)
) (
  input  logic [NCH-1:0]  valid,
  input  logic [CH_W-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [CH_W-1:0] grant_idx,
  output logic            grant_valid
);

  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b);
    int unsigned s;
    s = a + b;
    if (s >= NCH) s = s - NCH;
    return s;
  endfunction

  logic [NCH-1:0] rot;

  // rot[i] is the channel i positions after ptr
  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      rot[i] = valid[CH_W'(wrap_add(i, 32'(ptr)))];
    end
  end

  // First set bit of the rotated vector, mapped back to a real channel
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rot[i] && !grant_valid) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'(wrap_add(i, 32'(ptr)));
      end
    end
    grant = '0;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter sharing one synchronous memory port.
// Requests use valid/ready; the grant drives the memory strobes in the same
// cycle and the response (read data or write ack) returns on the issuing
// channel one cycle later, steered by a registered in-flight tag.
// Build option: define ARB_ROUND_ROBIN_EN for rotating priority; otherwise
// fixed priority with channel 0 highest.
// Ports:
//   clk, rst        : clock (rising edge), async active-low reset
//   req_valid_i     : per-channel request valid
//   req_ready_o     : per-channel grant (one-hot or zero, combinational)
//   req_we_i        : per-channel write enable (0 = read)
//   req_addr_i      : flattened addresses, channel k at [k*AWIDTH +: AWIDTH]
//   req_wdata_i     : flattened write data, channel k at [k*DWIDTH +: DWIDTH]
//   resp_valid_o    : per-channel response strobe
//   resp_data_o     : read data (0 for write acks)
//   mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o : memory request
//   mem_data_i      : memory read data, valid the cycle after a read strobe
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned NCH    = NCH_DEFAULT,
  parameter  int unsigned AWIDTH = 32,
  parameter  int unsigned DWIDTH = 32,
  localparam int unsigned CH_W   = ch_w(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        req_valid_i,
  output logic [NCH-1:0]        req_ready_o,
  input  logic [NCH-1:0]        req_we_i,
  input  logic [NCH*AWIDTH-1:0] req_addr_i,
  input  logic [NCH*DWIDTH-1:0] req_wdata_i,
  output logic [NCH-1:0]        resp_valid_o,
  output logic [DWIDTH-1:0]     resp_data_o,
  output logic [AWIDTH-1:0]     mem_addr_o,
  output logic [DWIDTH-1:0]     mem_data_o,
  output logic                  mem_read_en_o,
  output logic                  mem_write_en_o,
  input  logic [DWIDTH-1:0]     mem_data_i
);

  logic [NCH-1:0]  grant;
  logic [CH_W-1:0] grant_idx;
  logic            grant_valid;
  logic [CH_W-1:0] ptr;
  resp_tag_t       pend_q;

  arb_picker #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_picker (
    .valid       (req_valid_i),
    .ptr         (ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Channel after the winner gets top priority next; hold when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (32'(grant_idx) == NCH - 1) ? '0 : grant_idx + CH_W'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  assign req_ready_o = grant;

  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        mem_addr_o     = req_addr_i[i*AWIDTH +: AWIDTH];
        mem_read_en_o  = !req_we_i[i];
        mem_write_en_o = req_we_i[i];
        mem_data_o     = req_we_i[i] ? req_wdata_i[i*DWIDTH +: DWIDTH] : '0;
      end
    end
  end

  // Loaded every cycle; a reset between grant and response drops the access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
    end else begin
      pend_q.pend <= grant_valid;
      pend_q.ch   <= CH_W_MAX'(grant_idx);
      pend_q.rd   <= mem_read_en_o;
    end
  end

  always_comb begin
    resp_valid_o = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      resp_valid_o[i] = pend_q.pend && (pend_q.ch == CH_W_MAX'(i));
    end
    resp_data_o = pend_q.rd ? mem_data_i : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a 3-channel instance against a small
// synchronous memory model, plus a 1-channel instance against an
// address-derived data source.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 3-channel instance
  logic [2:0]  valid, we, ready, rvalid;
  logic [95:0] addr, wdata;
  logic [31:0] rdata, maddr, mdo, mdi;
  logic        mre, mwe;
  logic [31:0] mem [0:63];

  mem_port_arbiter #(
    .NCH    (3),
    .AWIDTH (32),
    .DWIDTH (32)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (valid),
    .req_ready_o    (ready),
    .req_we_i       (we),
    .req_addr_i     (addr),
    .req_wdata_i    (wdata),
    .resp_valid_o   (rvalid),
    .resp_data_o    (rdata),
    .mem_addr_o     (maddr),
    .mem_data_o     (mdo),
    .mem_read_en_o  (mre),
    .mem_write_en_o (mwe),
    .mem_data_i     (mdi)
  );

  // Synchronous memory; contents reloaded while reset is held
  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 64; k++) mem[k] <= '0;
      mem[1] <= 32'hDEADBEEF;
    end else begin
      if (mwe) mem[maddr[7:2]] <= mdo;
      if (mre) mdi <= mem[maddr[7:2]];
    end
  end

  // 1-channel instance
  logic        v1, we1, rdy1, rv1, mre1, mwe1;
  logic [31:0] a1, wd1, rd1, ma1, mdo1, mdi1;

  mem_port_arbiter #(
    .NCH    (1),
    .AWIDTH (32),
    .DWIDTH (32)
  ) u_dut1 (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (v1),
    .req_ready_o    (rdy1),
    .req_we_i       (we1),
    .req_addr_i     (a1),
    .req_wdata_i    (wd1),
    .resp_valid_o   (rv1),
    .resp_data_o    (rd1),
    .mem_addr_o     (ma1),
    .mem_data_o     (mdo1),
    .mem_read_en_o  (mre1),
    .mem_write_en_o (mwe1),
    .mem_data_i     (mdi1)
  );

  always @(posedge clk) mdi1 <= ma1 ^ 32'hA5A5_0000;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    valid[ch]          = v;
    we[ch]             = w;
    addr[ch*32 +: 32]  = a;
    wdata[ch*32 +: 32] = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  logic [2:0] e;

  initial begin
    valid = '0; we = '0; addr = '0; wdata = '0;
    v1 = 1'b0; we1 = 1'b0; a1 = '0; wd1 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata",  rdata,       32'h0);
    chk("rst_ready",  32'(ready),  32'h0);
    chk("rst_mre",    32'(mre),    32'h0);
    chk("rst_mwe",    32'(mwe),    32'h0);
    chk("rst_rv1",    32'(rv1),    32'h0);
    rst = 1'b1;

    // Single read on ch1
    set_ch(1, 1'b1, 1'b0, 32'h0100_0004, 32'h0);
    #1;
    chk("rd_ready", 32'(ready), 32'h2);
    chk("rd_mre",   32'(mre),   32'h1);
    chk("rd_mwe",   32'(mwe),   32'h0);
    chk("rd_maddr", maddr,      32'h0100_0004);
    chk("rd_mdo",   mdo,        32'h0);
    tick();
    chk("rd_rvalid", 32'(rvalid), 32'h2);
    chk("rd_rdata",  rdata,       32'hDEADBEEF);
    set_ch(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Write on ch2, then read of the same word on ch0
    set_ch(2, 1'b1, 1'b1, 32'h0100_0010, 32'h1234_5678);
    #1;
    chk("wr_ready", 32'(ready), 32'h4);
    chk("wr_mwe",   32'(mwe),   32'h1);
    chk("wr_mdo",   mdo,        32'h1234_5678);
    chk("wr_maddr", maddr,      32'h0100_0010);
    tick();
    chk("wr_ack_rvalid", 32'(rvalid), 32'h4);
    chk("wr_ack_rdata",  rdata,       32'h0);
    set_ch(2, 1'b0, 1'b0, 32'h0, 32'h0);
    set_ch(0, 1'b1, 1'b0, 32'h0100_0010, 32'h0);
    #1;
    chk("raw_ready", 32'(ready), 32'h1);
    chk("raw_mre",   32'(mre),   32'h1);
    tick();
    chk("raw_rvalid", 32'(rvalid), 32'h1);
    chk("raw_rdata",  rdata,       32'h1234_5678);
    set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Async reset between grant and response edge
    set_ch(1, 1'b1, 1'b0, 32'h0100_0004, 32'h0);
    tick();
    chk("mf_pre_rvalid", 32'(rvalid), 32'h2);
    chk("mf_ready",      32'(ready),  32'h2);
    rst = 1'b0;
    #1;
    chk("mf_rst_rvalid", 32'(rvalid), 32'h0);
    chk("mf_rst_rdata",  rdata,       32'h0);
    tick();
    chk("mf_dropped", 32'(rvalid), 32'h0);
    set_ch(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    set_ch(1, 1'b1, 1'b0, 32'h0100_0004, 32'h0);
    set_ch(2, 1'b1, 1'b0, 32'h0100_0010, 32'h0);
    #1;
    chk("mf_first_ready", 32'(ready), 32'h2);
    tick();
    chk("mf_first_rvalid", 32'(rvalid), 32'h2);
    chk("mf_first_rdata",  rdata,       32'hDEADBEEF);
    valid = '0;

    // All three valid for six cycles
    do_reset();
    set_ch(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    set_ch(1, 1'b1, 1'b0, 32'h0000_0024, 32'h0);
    set_ch(2, 1'b1, 1'b0, 32'h0000_0028, 32'h0);
    for (int i = 0; i < 6; i++) begin
      e = RR ? (3'b001 << (i % 3)) : 3'b001;
      #1;
      chk($sformatf("all_ready_%0d", i), 32'(ready), 32'(e));
      tick();
      chk($sformatf("all_rvalid_%0d", i), 32'(rvalid), 32'(e));
    end
    set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("drop0_ready", 32'(ready), 32'h2);
    tick();
    chk("drop0_rvalid", 32'(rvalid), 32'h2);
    valid = '0;

    // Withdrawn request on ch2 while ch0 holds the grant
    do_reset();
    set_ch(0, 1'b1, 1'b0, 32'h0100_0004, 32'h0);
    set_ch(2, 1'b1, 1'b0, 32'h0100_0010, 32'h0);
    #1;
    chk("wd_ready0", 32'(ready), 32'h1);
    chk("wd_maddr0", maddr,      32'h0100_0004);
    tick();
    chk("wd_rvalid0", 32'(rvalid), 32'h1);
    set_ch(2, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("wd_ready1", 32'(ready), 32'h1);
    chk("wd_maddr1", maddr,      32'h0100_0004);
    tick();
    chk("wd_rvalid1", 32'(rvalid), 32'h1);
    set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("wd_idle_ready", 32'(ready), 32'h0);
    chk("wd_idle_mre",   32'(mre),   32'h0);
    chk("wd_idle_maddr", maddr,      32'h0);
    tick();
    chk("wd_idle_rvalid", 32'(rvalid), 32'h0);

    // Single-channel instance, continuous valid
    v1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a1 = 32'h0000_0100 + 32'(4 * i);
      #1;
      chk($sformatf("n1_ready_%0d", i), 32'(rdy1), 32'h1);
      chk($sformatf("n1_mre_%0d", i),   32'(mre1), 32'h1);
      chk($sformatf("n1_maddr_%0d", i), ma1,       32'h0000_0100 + 32'(4 * i));
      tick();
      chk($sformatf("n1_rvalid_%0d", i), 32'(rv1), 32'h1);
      chk($sformatf("n1_rdata_%0d", i),  rd1,
          (32'h0000_0100 + 32'(4 * i)) ^ 32'hA5A5_0000);
    end
    v1 = 1'b0;
    #1;
    chk("n1_idle_ready", 32'(rdy1), 32'h0);
    tick();
    chk("n1_idle_rvalid", 32'(rv1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-channel arbiter that shares the single synchronous instruction/data memory among several requesters, such as fetch, a future load/store stage and the testbench probe port. It replaces the hard-wired two-way probe/PC mux in the pd top level. Each requester uses a valid/ready request handshake. Read data and write acknowledges are routed back to the issuing channel one cycle later via a registered in-flight tag.

## Interface
Parameters:
- NCH, 3, number of requester channels (≥1); channel 0 is highest-priority in fixed mode
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- CH_W, $clog2(NCH) (min 1), derived, channel index width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid_i  in  NCH  per-channel request valid
- req_ready_o  out  NCH  per-channel grant, one-hot or zero, combinational
- req_we_i  in  NCH  1 = write, 0 = read
- req_addr_i  in  NCH*AWIDTH  flattened; channel k at [k*AWIDTH +: AWIDTH]
- req_wdata_i  in  NCH*DWIDTH  flattened write data
- resp_valid_o  out  NCH  per-channel response strobe, registered
- resp_data_o  out  DWIDTH  read data (shared bus); 0 for write acks
- mem_addr_o  out  AWIDTH  to memory addr_i
- mem_data_o  out  DWIDTH  to memory data_i
- mem_read_en_o  out  1  to memory read_en_i
- mem_write_en_o  out  1  to memory write_en_i
- mem_data_i  in  DWIDTH  from memory data_o; valid the cycle after a read strobe

## Operation
- Each cycle at most one channel is granted: g = picker(req_valid_i, ptr). req_ready_o[g]=1 only if req_valid_i[g]=1.
- Handshake: transfer occurs when valid&&ready in the same cycle. The requester holds valid, addr, we and wdata stable until ready. Deasserting valid before ready is allowed (request withdrawn, no side effect).
- On grant: mem_addr_o=addr[g], mem_read_en_o=!we[g], mem_write_en_o=we[g], mem_data_o=we[g]?wdata[g]:0.
- No grant: all mem_* outputs 0.
- In-flight register: {pend, pend_ch, pend_rd} loaded every cycle. pend=grant_valid.
- Response: resp_valid_o[pend_ch]=pend (one-hot). resp_data_o=pend_rd?mem_data_i:0. Every granted write also returns an ack.
- Memory always accepts, so there is no backpressure from memory. Back-to-back grants to the same or different channels are allowed every cycle.
- Write at T followed by a read of the same address at T+1 returns the new data (memory write-first ordering).
- NCH=1: ready_o = valid_i, ptr fixed at 0.

## Timing
- Request to memory strobe: 0 cycles (combinational).
- Grant to resp_valid_o: exactly 1 cycle, for reads and writes.
- Throughput: 1 access per cycle aggregate.
- Reset (rst=0, async): resp_valid_o=0, resp_data_o=0, pend=0, pend_ch=0, ptr=0. req_ready_o and mem_* follow the combinational rules, and both are 0 while all valid inputs are 0.
- Reset asserted with a grant in flight: the response is dropped, never replayed. The requester must reissue after reset.
- Round-robin ptr update: on grant ptr ← (g+1) mod NCH, with wrap from NCH-1 to 0. ptr holds when there is no grant.

## Configuration
- ARB_ROUND_ROBIN_EN defined: rotating priority starting at ptr. No channel waits more than NCH-1 grants.
- Not defined: fixed priority, lowest index wins. ptr logic is compiled out and treated as constant 0.

## Structure
- Package mem_arb_pkg: CH_W helper function, resp-tag struct {pend, ch, rd}, NCH default constant.
- Sub-module arb_picker (combinational): rotate the valid vector by ptr, find the first set bit, rotate the result back, and output a one-hot grant plus an index. In fixed mode it is instantiated with ptr=0.

## Test plan
- Single read, NCH=3: ch1 reads addr 0x01000004 holding 0xDEADBEEF → ready_o=3'b010 at T, mem_read_en_o=1, resp_valid_o=3'b010 and resp_data_o=0xDEADBEEF at T+1.
- Write then read: ch2 writes 0x12345678 to 0x01000010 at T, ch0 reads the same address at T+1 → ack on ch2 at T+1 with data 0, ch0 gets 0x12345678 at T+2.
- All three valid for 6 cycles. RR build: grant order 0,1,2,0,1,2. Fixed build: 0 every cycle, and ch1/ch2 are starved until ch0 drops.
- Withdrawn request: ch2 valid for 1 cycle while ch0 holds the grant → no memory access or response for ch2.
- Async reset mid-flight: assert rst=0 between grant and response edge → resp_valid_o=0 immediately. After release ptr=0, and the first grant goes to the lowest valid channel.
- NCH=1 build: continuous valid → ready every cycle, one response per cycle with a 1-cycle lag.
